vga_fb_arbiter: RTL and testbench

- Shares one single-port pixel frame memory (NES 256x240 palette-index buffer) between the VGA scan-out reader and the PPU pixel writer.
- VGA reads always win, so scan-out timing from the sync generator is never disturbed.
- PPU writes go through a small FIFO and drain on idle memory cycles.
- A built-in clear engine fills the buffer with a constant colour on command, for example between frames or at boot.

---
 rtl/vga_fb_arbiter.sv | 179 +++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: single-port frame memory arbiter for the NES 256x240 buffer.
// VGA reads always win. PPU writes queue in a small FIFO and drain on idle cycles.
// The clear engine drains the FIFO, then fills MEM_WORDS words with CLEAR_COLOR.
// Optional build macro VGA_FB_ARB_STATS_EN adds a saturating write-stall counter.
module vga_fb_arbiter #(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       DATA_W      = 6,
  parameter int unsigned       MEM_WORDS   = 61440,
  parameter int unsigned       FIFO_DEPTH  = 4,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = 'h0F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef VGA_FB_ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [CNT_W-1:0]    fifo_cnt;
  logic                fifo_empty;
  logic                push, pop;
  logic                grant_clr, grant_fifo;
  logic                clr_last;
  logic                rd_pend;
  logic                clr_busy_nxt, clr_done_nxt;

  assign fifo_empty = (fifo_cnt == '0);
  assign clr_last   = (clr_cnt == ADDR_W'(MEM_WORDS - 1));
  assign wr_ready   = (fifo_cnt < CNT_W'(FIFO_DEPTH)) && (state == S_IDLE);
  assign push       = wr_req && wr_ready;
  assign pop        = grant_fifo;

  // Per-cycle arbitration: read, then clear write, then FIFO head write.
  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    grant_clr  = 1'b0;
    grant_fifo = 1'b0;
    if (rd_req) begin
      mem_en   = 1'b1;
      mem_addr = rd_addr;
    end else if (state == S_CLEAR) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = clr_cnt;
      mem_wdata = CLEAR_COLOR;
      grant_clr = 1'b1;
    end else if (!fifo_empty) begin
      mem_en     = 1'b1;
      mem_we     = 1'b1;
      mem_addr   = fifo_addr[rd_ptr];
      mem_wdata  = fifo_data[rd_ptr];
      grant_fifo = 1'b1;
    end
  end

  // Clear sequencer next-state decision.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (clr_start) state_nxt = S_DRAIN;
      S_DRAIN: if (fifo_empty) state_nxt = S_CLEAR;
      S_CLEAR: if (grant_clr && clr_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sequencer status outputs, computed one cycle ahead so they can be registered.
  always_comb begin
    clr_busy_nxt = (state_nxt != S_IDLE);
    clr_done_nxt = (state == S_CLEAR) && grant_clr && clr_last;
  end

  // Sequencer state and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      clr_busy <= clr_busy_nxt;
      clr_done <= clr_done_nxt;
    end
  end

  // Clear address counter: zeroed on DRAIN->CLEAR, advances only on granted clear writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt <= '0;
    end else if (state == S_DRAIN && fifo_empty) begin
      clr_cnt <= '0;
    end else if (grant_clr && !clr_last) begin
      clr_cnt <= clr_cnt + ADDR_W'(1);
    end
  end

  // FIFO storage needs no reset; the occupancy count alone defines validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Read pipeline: request cycle, memory latency cycle, then registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_pend  <= rd_req;
      rd_valid <= rd_pend;
      if (rd_pend) rd_data <= mem_rdata;
    end
  end

`ifdef VGA_FB_ARB_STATS_EN
  // Saturating count of cycles the writer was held off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stats_clr) begin
      stall_cnt <= '0;
    end else if (wr_req && !wr_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Testbench for vga_fb_arbiter: transaction-level reference model with a queue for
// pending writes, a shadow memory, and a behavioural single-port memory.
module tb_vga_fb_arbiter;

  localparam int unsigned WORDS = 61440;
  localparam int unsigned DEPTH = 4;
  localparam logic [5:0]  CC    = 6'h0F;

  logic        clk, rst;
  logic        rd_req, rd_valid;
  logic [15:0] rd_addr;
  logic [5:0]  rd_data;
  logic        wr_req, wr_ready;
  logic [15:0] wr_addr;
  logic [5:0]  wr_data;
  logic        clr_start, clr_busy, clr_done;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [5:0]  mem_wdata, mem_rdata;
`ifdef VGA_FB_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] stall_cnt;
`endif

  vga_fb_arbiter #(.ADDR_W(16), .DATA_W(6), .MEM_WORDS(WORDS), .FIFO_DEPTH(DEPTH), .CLEAR_COLOR(CC)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef VGA_FB_ARB_STATS_EN
    , .stats_clr(stats_clr), .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Environment memory (what the DUT actually talks to) and the model's view of it.
  logic [5:0] mem     [65536];
  logic [5:0] ref_mem [65536];

  typedef struct {
    logic [15:0] a;
    logic [5:0]  d;
  } wr_t;

  // Reference model state
  wr_t         q[$];
  bit          m_drain, m_clear, m_done;
  int unsigned m_cnt;
  bit          rv1, rv2;
  logic [5:0]  rd1, rd2, rdout;

  // Clear-length measurement from observed DUT behaviour
  bit meas_arm, meas_on, done_seen;
  int meas_n, meas_r, done_pulses;

  task automatic model_reset();
    q.delete();
    m_drain = 0; m_clear = 0; m_done = 0; m_cnt = 0;
    rv1 = 0; rv2 = 0; rd1 = '0; rd2 = '0; rdout = '0;
  endtask

  // One clock: check at the negedge, advance the model, service memory after posedge.
  task automatic tick();
    bit          ready, empty0;
    logic        e_en, e_we;
    logic [15:0] e_addr;
    logic [5:0]  e_wd;
    logic        c_en, c_we;
    logic [15:0] c_a;
    logic [5:0]  c_d;
    @(negedge clk);
    ready  = (q.size() < DEPTH) && !m_drain && !m_clear;
    empty0 = (q.size() == 0);
    e_en = 0; e_we = 0; e_addr = '0; e_wd = '0;
    if (rd_req) begin
      e_en = 1; e_addr = rd_addr;
    end else if (m_clear) begin
      e_en = 1; e_we = 1; e_addr = 16'(m_cnt); e_wd = CC;
    end else if (!empty0) begin
      e_en = 1; e_we = 1; e_addr = q[0].a; e_wd = q[0].d;
    end
    check_val("wr_ready", wr_ready, ready);
    check_val("mem_en", mem_en, e_en);
    if (e_en) begin
      check_val("mem_we", mem_we, e_we);
      check_val("mem_addr", mem_addr, e_addr);
      if (e_we) check_val("mem_wdata", mem_wdata, e_wd);
    end
    check_val("clr_busy", clr_busy, m_drain || m_clear);
    check_val("clr_done", clr_done, m_done);
    check_val("rd_valid", rd_valid, rv2);
    check_val("rd_data", rd_data, rdout);

    if (meas_arm && !meas_on && clr_busy && mem_we && mem_addr == 16'd0 && mem_wdata == CC)
      meas_on = 1;
    if (meas_arm && clr_done) done_pulses++;
    if (meas_on) begin
      if (clr_done) begin
        meas_on = 0; done_seen = 1;
      end else begin
        meas_n++;
        if (rd_req) meas_r++;
      end
    end
    c_en = mem_en; c_we = mem_we; c_a = mem_addr; c_d = mem_wdata;

    // read pipeline (old data on same-address conflicts: read wins, no write this cycle)
    rv2 = rv1; rd2 = rd1;
    if (rv2) rdout = rd2;
    rv1 = rd_req; rd1 = ref_mem[rd_addr];
    if (e_we) ref_mem[e_addr] = e_wd;
    if (e_we && !m_clear && !rd_req) void'(q.pop_front());
    m_done = 0;
    if (m_clear) begin
      if (!rd_req) begin
        if (m_cnt == WORDS - 1) begin m_clear = 0; m_done = 1; end
        else m_cnt++;
      end
    end else if (m_drain) begin
      if (empty0) begin m_drain = 0; m_clear = 1; m_cnt = 0; end
    end else if (clr_start) begin
      m_drain = 1;
    end
    if (wr_req && ready) q.push_back('{a: wr_addr, d: wr_data});

    @(posedge clk);
    #1;
    if (c_en) begin
      if (c_we) mem[c_a] = c_d;
      else mem_rdata = mem[c_a];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_wr_ready"}, wr_ready, 1);
    check_val({tag, "_rd_valid"}, rd_valid, 0);
    check_val({tag, "_rd_data"}, rd_data, 0);
    check_val({tag, "_clr_busy"}, clr_busy, 0);
    check_val({tag, "_clr_done"}, clr_done, 0);
    check_val({tag, "_mem_en"}, mem_en, 0);
    check_val({tag, "_mem_we"}, mem_we, 0);
  endtask

  initial begin
    logic [5:0] v;
    for (int i = 0; i < 65536; i++) begin
      v = 6'($urandom);
      mem[i] = v; ref_mem[i] = v;
    end
    mem[16'h0010] = 6'd5; ref_mem[16'h0010] = 6'd5;
    mem[16'h0011] = 6'd6; ref_mem[16'h0011] = 6'd6;
    mem[16'h0012] = 6'd7; ref_mem[16'h0012] = 6'd7;
    mem_rdata = '0;
    rst = 1; rd_req = 0; rd_addr = '0; wr_req = 0; wr_addr = '0; wr_data = '0; clr_start = 0;
`ifdef VGA_FB_ARB_STATS_EN
    stats_clr = 0;
`endif
    meas_arm = 0; meas_on = 0; done_seen = 0; meas_n = 0; meas_r = 0; done_pulses = 0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 0;
    repeat (2) tick();

    // Three back-to-back reads of preloaded pixels 5, 6, 7
    rd_req = 1;
    for (int i = 0; i < 3; i++) begin
      rd_addr = 16'h0010 + 16'(i);
      tick();
    end
    rd_req = 0;
    repeat (3) tick();

    // Reads starve writes: fill the FIFO, 5th attempt refused, then drain in order
    rd_req = 1;
    for (int i = 0; i < 5; i++) begin
      rd_addr = 16'($urandom);
      wr_req = 1; wr_addr = 16'($urandom_range(1, 65535)); wr_data = 6'($urandom);
      tick();
    end
    wr_req = 0; rd_req = 0;
    repeat (6) tick();

    // Random mixed traffic
    for (int i = 0; i < 400; i++) begin
      rd_req = ($urandom_range(0, 1) == 1); rd_addr = 16'($urandom);
      wr_req = ($urandom_range(0, 1) == 1); wr_addr = 16'($urandom); wr_data = 6'($urandom);
      tick();
    end
    rd_req = 0; wr_req = 0;
    repeat (6) tick();

    // Two queued writes, clear started, reset at counter 1000
    rd_req = 1;
    for (int i = 0; i < 2; i++) begin
      rd_addr = 16'($urandom);
      wr_req = 1; wr_addr = 16'($urandom_range(1, 65535)); wr_data = 6'($urandom);
      tick();
    end
    wr_req = 0; rd_req = 0; clr_start = 1;
    tick();
    clr_start = 0;
    for (int i = 0; i < 3000 && !(m_clear && m_cnt == 1000); i++) tick();
    rst = 1;
    model_reset();
    #1;
    check_reset_outputs("midclr");
    tick();
    rst = 0;
    tick();

    // Full clear restarting from 0, reads on alternate cycles early in the clear
    meas_arm = 1;
    clr_start = 1;
    tick();
    clr_start = 0;
    for (int i = 0; i < 70000 && !done_seen; i++) begin
      rd_req = (i < 2000) ? i[0] : 1'b0;
      rd_addr = 16'($urandom);
      tick();
    end
    rd_req = 0;
    check_val("clr_done_seen", done_seen, 1);
    check_val("clr_len", meas_n, WORDS + meas_r);
    check_val("clr_done_pulses", done_pulses, 1);
    repeat (4) tick();
    check_val("cleared_first", mem[16'd0], CC);
    check_val("cleared_last", mem[16'(WORDS - 1)], CC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
